// File: rtl/kmeans_accum_bank.sv
// kmeans_accum_bank: per-centroid accumulator bank for the k-means classify stage.
// Points enter through a 2-stage pipe: stage 1 registers the point and index, and
// stage 2 writes the target centroid. The bank is drained one centroid per handshake.
// Optional build macro KM_ACC_SATURATE_EN: overflowing sums and counts clamp to their
// maximum value. Without it they wrap modulo their width. The ovf flag is set either way.

// One centroid: coordinate-wise running sum, point count and sticky overflow.
module kmeans_cent_acc #(
  parameter int DIM     = 7,
  parameter int COORD_W = 13,
  parameter int ACC_W   = 22,
  parameter int CNT_W   = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr,
  input  logic                            we,
  input  logic [DIM-1:0][COORD_W-1:0]     point,
  output logic [DIM-1:0][ACC_W-1:0]       sum,
  output logic [CNT_W-1:0]                cnt,
  output logic                            ovf
);
  logic [DIM-1:0][ACC_W:0]   sum_ext;
  logic [DIM-1:0][ACC_W-1:0] sum_nxt;
  logic [DIM-1:0]            carry;
  logic [CNT_W:0]            cnt_ext;
  logic [CNT_W-1:0]          cnt_nxt;

  // Zero-extend each coordinate and keep the carry bit to detect overflow.
  for (genvar d = 0; d < DIM; d++) begin : g_dim
    assign sum_ext[d] = {1'b0, sum[d]} + {{(ACC_W + 1 - COORD_W){1'b0}}, point[d]};
    assign carry[d]   = sum_ext[d][ACC_W];
`ifdef KM_ACC_SATURATE_EN
    assign sum_nxt[d] = carry[d] ? {ACC_W{1'b1}} : sum_ext[d][ACC_W-1:0];
`else
    assign sum_nxt[d] = sum_ext[d][ACC_W-1:0];
`endif
  end

  assign cnt_ext = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
`ifdef KM_ACC_SATURATE_EN
  assign cnt_nxt = cnt_ext[CNT_W] ? {CNT_W{1'b1}} : cnt_ext[CNT_W-1:0];
`else
  assign cnt_nxt = cnt_ext[CNT_W-1:0];
`endif

  // Accumulate on write. Clear has priority over a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (we) begin
      sum <= sum_nxt;
      cnt <= cnt_nxt;
      if ((|carry) || cnt_ext[CNT_W]) ovf <= 1'b1;
    end
  end
endmodule

module kmeans_accum_bank #(
  parameter int CENT_NUM = 8,
  parameter int DIM      = 7,
  parameter int COORD_W  = 13,
  parameter int ACC_W    = 22,
  parameter int CNT_W    = 10,
  parameter int IDX_W    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IDX_W-1:0]         in_index,
  input  logic [DIM*COORD_W-1:0]   in_point,
  input  logic                     clr,
  input  logic                     drain_start,
  input  logic                     drain_clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IDX_W-1:0]         out_index,
  output logic [DIM*ACC_W-1:0]     out_sum,
  output logic [CNT_W-1:0]         out_cnt,
  output logic                     out_ovf,
  output logic                     drain_done,
  output logic                     idx_err
);
  typedef enum logic [1:0] {ACCUM, FLUSH, DRAIN, DONE} state_t;

  state_t                                state, state_nxt;
  logic [1:0]                            vld_pipe;   // [0] stage 1 holds a point, [1] bank write just landed
  logic [IDX_W-1:0]                      s1_idx;
  logic [DIM-1:0][COORD_W-1:0]           s1_point;
  logic                                  accept, clr_eff, bank_clr, drain_clr_q, s1_oor, last_beat;
  logic [IDX_W-1:0]                      beat;
  logic [CENT_NUM-1:0]                   we;
  logic [CENT_NUM-1:0][DIM-1:0][ACC_W-1:0] bank_sum;
  logic [CENT_NUM-1:0][CNT_W-1:0]        bank_cnt;
  logic [CENT_NUM-1:0]                   bank_ovf;

  assign in_ready  = (state == ACCUM) & ~drain_start & ~clr & ~rst;
  assign accept    = in_valid & in_ready;
  assign clr_eff   = clr & (state == ACCUM);
  assign bank_clr  = clr_eff | ((state == DONE) & drain_clr_q);
  assign s1_oor    = {1'b0, s1_idx} >= (IDX_W + 1)'(CENT_NUM);
  assign last_beat = beat == IDX_W'(CENT_NUM - 1);

  // Pipe valids. Clear kills any in-flight point.
  always_ff @(posedge clk) begin
    if (rst || clr_eff) vld_pipe <= '0;
    else                vld_pipe <= {vld_pipe[0], accept};
  end

  // Stage 1 point and index capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_idx   <= '0;
      s1_point <= '0;
    end else if (accept) begin
      s1_idx   <= in_index;
      s1_point <= in_point;
    end
  end

  // Stage 2: route the registered point to its centroid. Out-of-range indices write nothing.
  for (genvar c = 0; c < CENT_NUM; c++) begin : g_cent
    assign we[c] = vld_pipe[0] & (s1_idx == IDX_W'(c));
    kmeans_cent_acc #(.DIM(DIM), .COORD_W(COORD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) u_acc (
      .clk   (clk),
      .rst   (rst),
      .clr   (bank_clr),
      .we    (we[c]),
      .point (s1_point),
      .sum   (bank_sum[c]),
      .cnt   (bank_cnt[c]),
      .ovf   (bank_ovf[c])
    );
  end

  // Sticky out-of-range flag, set when the dropped point reaches stage 2.
  always_ff @(posedge clk) begin
    if (rst || bank_clr)          idx_err <= 1'b0;
    else if (vld_pipe[0] && s1_oor) idx_err <= 1'b1;
  end

  // Remember whether this drain should zero the bank when it finishes.
  always_ff @(posedge clk) begin
    if (rst)                                            drain_clr_q <= 1'b0;
    else if (state == ACCUM && drain_start && !clr)     drain_clr_q <= drain_clear;
  end

  // Drain beat counter. It advances on each accepted beat and wraps after the last one.
  always_ff @(posedge clk) begin
    if (rst)                                beat <= '0;
    else if (state == DRAIN && out_ready)   beat <= last_beat ? '0 : beat + 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  // Next state. A clear wins over a same-cycle drain request.
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM: if (drain_start && !clr)      state_nxt = FLUSH;
      FLUSH: if (vld_pipe == 2'b00)        state_nxt = DRAIN;
      DRAIN: if (out_ready && last_beat)   state_nxt = DONE;
      DONE:                                state_nxt = ACCUM;
      default:                             state_nxt = ACCUM;
    endcase
  end

  // Drain payload mux. The bank is frozen during DRAIN, so the payload holds across stalls.
  always_comb begin
    out_valid  = (state == DRAIN);
    drain_done = (state == DONE);
    out_index  = '0;
    out_sum    = '0;
    out_cnt    = '0;
    out_ovf    = 1'b0;
    if (state == DRAIN) begin
      out_index = beat;
      for (int c = 0; c < CENT_NUM; c++) begin
        if (beat == IDX_W'(c)) begin
          out_sum = bank_sum[c];
          out_cnt = bank_cnt[c];
          out_ovf = bank_ovf[c];
        end
      end
    end
  end
endmodule
